// File: rtl/cdb_arbiter_pkg.sv
// Shared configuration for the CDB arbiter: source indices, RobId width default
// and a saturating increment used by the optional CDB_PERF_EN counters.
package cdb_arbiter_pkg;

    localparam int CDB_ROB_LOG = 4;
    localparam int CDB_VALUE_W = 32;

    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_LSB = 1;
    localparam int CDB_SRC_BR  = 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO for the CDB arbiter. next_count exposes the count
// after this edge so the parent can register an exact ready.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = CDB_ROB_LOG + CDB_VALUE_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] next_count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push && (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Occupancy after this edge; clear wins over any same-edge push or pop.
    always_comb begin
        next_count = count_r;
        if (!rdy) begin
            next_count = count_r;
        end else if (clear) begin
            next_count = {CW{1'b0}};
        end else begin
            next_count = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Storage and pointers; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (rdy) begin
            if (clear) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_ok_s) begin
                    mem_r[wr_ptr_r] <= din;
                    wr_ptr_r        <= wr_ptr_r + PW'(1);
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
            end
            count_r <= next_count;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered common data bus from N_SRC result
// FIFOs. Defining CDB_PERF_EN adds per-source grant and stall counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_LOG = CDB_ROB_LOG,
    parameter int N_SRC   = 3,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    input  logic [N_SRC-1:0]       src_valid,
    output logic [N_SRC-1:0]       src_ready,
    input  logic [N_SRC*ROB_LOG-1:0] src_robid,
    input  logic [N_SRC*32-1:0]    src_value,
    output logic                   cdb_valid,
    output logic [ROB_LOG-1:0]     cdb_robid,
    output logic [31:0]            cdb_value,
    output logic [1:0]             cdb_src
`ifdef CDB_PERF_EN
   ,output logic [N_SRC*32-1:0]    perf_grant_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int EW = ROB_LOG + 32;
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0]    head_s       [N_SRC];
    logic [CW-1:0]    count_s      [N_SRC];
    logic [CW-1:0]    next_count_s [N_SRC];
    logic [N_SRC-1:0] push_s;
    logic [N_SRC-1:0] pop_s;
    logic [N_SRC-1:0] nonempty_s;
    logic [SW-1:0]    rr_ptr_r;
    logic [SW-1:0]    grant_s;
    logic             grant_vld_s;

    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_SRC) begin
            s = s - N_SRC;
        end else begin
            s = s;
        end
        return SW'(s);
    endfunction

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign push_s[g]     = src_valid[g] & src_ready[g];
        assign pop_s[g]      = grant_vld_s && (grant_s == SW'(g));
        assign nonempty_s[g] = (count_s[g] != {CW{1'b0}});

        cdb_src_fifo #(
            .DEPTH (DEPTH),
            .W     (EW)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .rdy        (rdy),
            .clear      (clear),
            .push       (push_s[g]),
            .pop        (pop_s[g]),
            .din        ({src_robid[g*ROB_LOG +: ROB_LOG], src_value[g*32 +: 32]}),
            .head       (head_s[g]),
            .count      (count_s[g]),
            .next_count (next_count_s[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping modulo N_SRC.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = {SW{1'b0}};
        for (int k = 0; k < N_SRC; k++) begin
            if (!grant_vld_s && nonempty_s[wrap_idx(rr_ptr_r, k)]) begin
                grant_vld_s = 1'b1;
                grant_s     = wrap_idx(rr_ptr_r, k);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Broadcast register, round-robin pointer and exact registered ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_robid <= {ROB_LOG{1'b0}};
            cdb_value <= 32'h0000_0000;
            cdb_src   <= 2'd0;
            src_ready <= {N_SRC{1'b0}};
            rr_ptr_r  <= {SW{1'b0}};
        end else if (rdy) begin
            for (int i = 0; i < N_SRC; i++) begin
                src_ready[i] <= (next_count_s[i] < CW'(DEPTH));
            end
            if (clear) begin
                cdb_valid <= 1'b0;
                rr_ptr_r  <= {SW{1'b0}};
            end else if (grant_vld_s) begin
                cdb_valid              <= 1'b1;
                {cdb_robid, cdb_value} <= head_s[grant_s];
                cdb_src                <= 2'(grant_s);
                rr_ptr_r               <= wrap_idx(grant_s, 1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

`ifdef CDB_PERF_EN
    // Saturating grant/stall counters; only rst zeroes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_grant_cnt <= {(N_SRC*32){1'b0}};
            perf_stall_cnt <= 32'h0000_0000;
        end else if (rdy) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (pop_s[i] && !clear) begin
                    perf_grant_cnt[i*32 +: 32] <= sat_inc(perf_grant_cnt[i*32 +: 32]);
                end
            end
            if (|(src_valid & ~src_ready)) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
        end
    end
`endif

endmodule
